// File: rtl/pio_avalon_master_pkg.sv
// Shared types and constants for the PIO Avalon-MM master and related bus helpers.
package pio_avalon_pkg;
  localparam int AVM_DATA_W = 32;
  localparam int TIMEOUT_W  = 16;

  // Register word offsets of a standard PIO slave.
  localparam int REG_DATA    = 0;
  localparam int REG_DIR     = 1;
  localparam int REG_IRQMASK = 2;
  localparam int REG_EDGE    = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    LAT_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;
endpackage

// File: rtl/pio_avalon_master_if.sv
// Command/response port plus Avalon-MM initiator signals of the PIO master.
interface pio_avalon_master_if #(
  parameter int ADDR_W = 2
) ();
  import pio_avalon_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_address;
  logic [AVM_DATA_W-1:0] cmd_writedata;

  logic                  rsp_valid;
  logic [AVM_DATA_W-1:0] rsp_readdata;
  logic                  rsp_timeout;
  logic [ADDR_W-1:0]     rsp_address;

  logic                  avm_chipselect;
  logic                  avm_write_n;
  logic                  avm_read_n;
  logic [ADDR_W-1:0]     avm_address;
  logic [AVM_DATA_W-1:0] avm_writedata;
  logic [AVM_DATA_W-1:0] avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
    output cmd_ready,
    output rsp_valid, rsp_readdata, rsp_timeout, rsp_address,
    output avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata,
    input  cmd_ready,
    input  rsp_valid, rsp_readdata, rsp_timeout, rsp_address,
    input  avm_chipselect, avm_write_n, avm_read_n, avm_address, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/pio_avalon_master_timeout.sv
// Stall-cycle counter for bus masters; expired is high while the count sits at limit.
module avm_timeout_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Saturate at the limit so a master that ignores expired never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (en_i && cnt_q != limit_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == limit_i);
endmodule

// File: rtl/pio_avalon_master.sv
// Single-outstanding Avalon-MM initiator turning valid/ready commands into PIO reads/writes.
module pio_avalon_master
  import pio_avalon_pkg::*;
#(
  parameter int ADDR_W         = 2,
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset_n,
  pio_avalon_master_if.master bus
);
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_to_q, rsp_to_d;
  logic                  cs_q, cs_d;
  logic                  write_n_q, write_n_d;
  logic                  read_n_q, read_n_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [AVM_DATA_W-1:0] wdata_q, wdata_d;
  logic [AVM_DATA_W-1:0] rdata_q, rdata_d;

  logic cmd_fire, stalled, expired;

  assign cmd_fire = cmd_ready_q && bus.cmd_valid;
  assign stalled  = bus.avm_waitrequest;

  avm_timeout_counter #(.W(TIMEOUT_W)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (cmd_fire),
    .en_i     (state_q == ACCESS && stalled),
    .limit_i  (TO_LIMIT),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_fire) state_d = ACCESS;
      ACCESS: begin
        if (!stalled) state_d = (!wr_q && READ_LATENCY == 1) ? LAT_WAIT : RESP;
        else if (expired) state_d = RESP;
      end
      LAT_WAIT: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Every output is a register; this block only computes their next values.
  always_comb begin
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_to_d    = rsp_to_q;
    cs_d        = cs_q;
    write_n_d   = write_n_q;
    read_n_d    = read_n_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          cmd_ready_d = 1'b0;
          cs_d        = 1'b1;
          write_n_d   = ~bus.cmd_write;
          read_n_d    = bus.cmd_write;
          wr_d        = bus.cmd_write;
          addr_d      = bus.cmd_address;
          wdata_d     = bus.cmd_writedata;
        end
      end
      ACCESS: begin
        if (!stalled || expired) begin
          cs_d      = 1'b0;
          write_n_d = 1'b1;
          read_n_d  = 1'b1;
        end
        if (!stalled) begin
          if (wr_q) begin
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
          end else if (READ_LATENCY == 0) begin
            rdata_d     = bus.avm_readdata;
            rsp_valid_d = 1'b1;
          end
        end else if (expired) begin
          rdata_d     = '0;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      LAT_WAIT: begin
        rdata_d     = bus.avm_readdata;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        rsp_valid_d = 1'b0;
        rsp_to_d    = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_to_q    <= 1'b0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_to_q    <= rsp_to_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_timeout    = rsp_to_q;
  assign bus.rsp_readdata   = rdata_q;
  assign bus.rsp_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_read_n     = read_n_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;
endmodule

// File: tb/tb_pio_avalon_master.sv
// Two masters (read latency 0 and 1, timeout 4) against PIO slave models, checked per cycle.
module tb_pio_avalon_master;
  import pio_avalon_pkg::*;

  localparam int AW = 2;
  localparam int TO = 4;
  localparam int NV = 13;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          cmd_valid = '0, cmd_write = '0;
  logic [1:0][AW-1:0]  cmd_address = '0;
  logic [1:0][31:0]    cmd_writedata = '0;
  int                  stall_cfg [2] = '{0, 0};
  int                  cur_vec [2] = '{0, 0};

  logic [1:0]          cmd_ready, rsp_valid, rsp_timeout, cs, write_n, read_n, waitreq;
  logic [1:0][AW-1:0]  rsp_address, avm_address;
  logic [1:0][31:0]    rsp_readdata, avm_writedata, avm_readdata;
  logic [1:0][2:0]     out_port;

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] wdata;
    int          stall;
    bit          b2b;
    logic [31:0] rdata;
    bit          to;
    int          k0;
    int          k1;
  } vec_t;
  vec_t vt [NV+1];

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[lat%0d] @%0t: got %h, want %h", nm, g, $time, act, exp);
    end
  endfunction

  // Instance g has READ_LATENCY g; each gets its own PIO slave model.
  for (genvar g = 0; g < 2; g++) begin : ch
    pio_avalon_master_if #(.ADDR_W(AW)) bus ();

    pio_avalon_master #(.ADDR_W(AW), .READ_LATENCY(g), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    assign bus.cmd_valid     = cmd_valid[g];
    assign bus.cmd_write     = cmd_write[g];
    assign bus.cmd_address   = cmd_address[g];
    assign bus.cmd_writedata = cmd_writedata[g];
    assign cmd_ready[g]      = bus.cmd_ready;
    assign rsp_valid[g]      = bus.rsp_valid;
    assign rsp_timeout[g]    = bus.rsp_timeout;
    assign rsp_readdata[g]   = bus.rsp_readdata;
    assign rsp_address[g]    = bus.rsp_address;
    assign cs[g]             = bus.avm_chipselect;
    assign write_n[g]        = bus.avm_write_n;
    assign read_n[g]         = bus.avm_read_n;
    assign avm_address[g]    = bus.avm_address;
    assign avm_writedata[g]  = bus.avm_writedata;

    logic [31:0] smem [4] = '{default: 32'h0};
    int cs_cyc = 0;

    assign waitreq[g]          = cs[g] && (cs_cyc < stall_cfg[g]);
    assign bus.avm_waitrequest = waitreq[g];
    assign bus.avm_readdata    = avm_readdata[g];
    assign out_port[g]         = smem[REG_DATA][2:0];

    always @(posedge clk) begin
      cs_cyc <= cs[g] ? cs_cyc + 1 : 0;
      if (cs[g] && !write_n[g] && !waitreq[g]) smem[avm_address[g]] <= avm_writedata[g];
    end

    if (g == 0) begin : l0
      assign avm_readdata[g] = (cs[g] && !read_n[g] && !waitreq[g]) ? smem[avm_address[g]] : 32'hDEAD_BEEF;
    end else begin : l1
      logic          rd_pend = 1'b0;
      logic [AW-1:0] rd_addr = '0;
      always @(posedge clk) begin
        rd_pend <= cs[g] && !read_n[g] && !waitreq[g];
        rd_addr <= avm_address[g];
      end
      assign avm_readdata[g] = rd_pend ? smem[rd_addr] : 32'hDEAD_BEEF;
    end
  end

  // Transaction-timeline model: k counts cycles since the accepting edge.
  bit          m_busy [2] = '{0, 0};
  bit          m_wr   [2] = '{0, 0};
  bit          m_to   [2] = '{0, 0};
  int          m_k    [2] = '{0, 0};
  int          m_v    [2] = '{0, 0};
  int          m_S    [2] = '{0, 0};
  int          m_L    [2] = '{0, 0};
  int          m_acc  [2] = '{0, 0};
  logic [AW-1:0] m_addr [2] = '{'0, '0};
  logic [31:0] m_wdata [2] = '{0, 0};
  logic [31:0] m_rdata [2] = '{0, 0};
  logic [31:0] m_mem [2][4] = '{default: 32'h0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) m_busy[g] <= 1'b0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (m_busy[g]) begin
          if (m_wr[g] && !m_to[g] && m_k[g] == m_S[g]) m_mem[g][m_addr[g]] <= m_wdata[g];
          if (m_k[g] == m_S[g] + m_L[g] + 1) m_busy[g] <= 1'b0;
          else                               m_k[g] <= m_k[g] + 1;
        end else if (cmd_valid[g]) begin
          m_busy[g]  <= 1'b1;
          m_k[g]     <= 1;
          m_v[g]     <= cur_vec[g];
          m_acc[g]   <= m_acc[g] + 1;
          m_wr[g]    <= cmd_write[g];
          m_addr[g]  <= cmd_address[g];
          m_wdata[g] <= cmd_writedata[g];
          m_to[g]    <= stall_cfg[g] >= TO;
          m_S[g]     <= (stall_cfg[g] >= TO) ? TO : stall_cfg[g] + 1;
          m_L[g]     <= (!cmd_write[g] && stall_cfg[g] < TO && g == 1) ? 1 : 0;
          m_rdata[g] <= (cmd_write[g] || stall_cfg[g] >= TO) ? 32'h0 : m_mem[g][cmd_address[g]];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin : per_g
      logic ecs, ersp;
      ecs  = m_busy[g] && m_k[g] <= m_S[g];
      ersp = m_busy[g] && m_k[g] == m_S[g] + m_L[g] + 1;
      chk("cmd_ready", g, 32'(cmd_ready[g]), 32'(!m_busy[g]));
      chk("chipselect", g, 32'(cs[g]), 32'(ecs));
      chk("write_n", g, 32'(write_n[g]), 32'(!(ecs && m_wr[g])));
      chk("read_n", g, 32'(read_n[g]), 32'(!(ecs && !m_wr[g])));
      chk("rsp_valid", g, 32'(rsp_valid[g]), 32'(ersp));
      if (ecs) begin
        chk("avm_address", g, 32'(avm_address[g]), 32'(m_addr[g]));
        if (m_wr[g]) chk("avm_writedata", g, avm_writedata[g], m_wdata[g]);
      end
      if (ersp) begin
        chk("rsp_address", g, 32'(rsp_address[g]), 32'(m_addr[g]));
        chk("rsp_timeout", g, 32'(rsp_timeout[g]), 32'(m_to[g]));
        chk("rsp_readdata", g, rsp_readdata[g], m_rdata[g]);
        chk("rsp_readdata_lit", g, rsp_readdata[g], vt[m_v[g]].rdata);
        chk("rsp_timeout_lit", g, 32'(rsp_timeout[g]), 32'(vt[m_v[g]].to));
        chk("rsp_cycle_lit", g, 32'(m_k[g]), 32'((g == 0) ? vt[m_v[g]].k0 : vt[m_v[g]].k1));
        if (m_v[g] == 0) chk("out_port_lit", g, 32'(out_port[g]), 32'h5);
        else             chk("out_port", g, 32'(out_port[g]), 32'(m_mem[g][REG_DATA][2:0]));
      end
      if (!reset_n) begin
        chk("rst_avm_address", g, 32'(avm_address[g]), 32'h0);
        chk("rst_rsp_readdata", g, rsp_readdata[g], 32'h0);
      end
    end
  end

  task automatic present(input int i);
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g]     = 1'b1;
      cmd_write[g]     = vt[i].wr;
      cmd_address[g]   = AW'(vt[i].addr);
      cmd_writedata[g] = vt[i].wdata;
      stall_cfg[g]     = vt[i].stall;
      cur_vec[g]       = i;
    end
  endtask

  task automatic wait_accept();
    int a0 [2];
    int n;
    a0[0] = m_acc[0];
    a0[1] = m_acc[1];
    n = 0;
    while (cmd_valid != 2'b00) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) if (m_acc[g] != a0[g]) cmd_valid[g] = 1'b0;
      n++;
      if (n > 200) begin
        $display("FAIL accept_bound: still waiting after %0d cycles, want < 200", n);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy[0] || m_busy[1]) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        $display("FAIL idle_bound: still busy after %0d cycles, want < 200", n);
        $fatal(1);
      end
    end
  endtask

  initial begin
    //        wr    addr wdata          stall b2b  rdata          to    k0 k1
    vt[0]  = '{1'b1, 0, 32'h0000_0005,  0, 1'b0, 32'h0,          1'b0, 2, 2};
    vt[1]  = '{1'b1, 0, 32'h0000_0003,  3, 1'b0, 32'h0,          1'b0, 5, 5};
    vt[2]  = '{1'b0, 0, 32'h0,          0, 1'b0, 32'h0000_0003,  1'b0, 2, 3};
    vt[3]  = '{1'b1, 1, 32'hA5A5_0001,  1, 1'b0, 32'h0,          1'b0, 3, 3};
    vt[4]  = '{1'b0, 1, 32'h0,          2, 1'b0, 32'hA5A5_0001,  1'b0, 4, 5};
    vt[5]  = '{1'b0, 2, 32'h0,         10, 1'b0, 32'h0,          1'b1, 5, 5};
    vt[6]  = '{1'b1, 2, 32'h0000_0007,  3, 1'b0, 32'h0,          1'b0, 5, 5};
    vt[7]  = '{1'b0, 2, 32'h0,          3, 1'b0, 32'h0000_0007,  1'b0, 5, 6};
    vt[8]  = '{1'b1, 3, 32'h0000_0012,  0, 1'b0, 32'h0,          1'b0, 2, 2};
    vt[9]  = '{1'b1, 3, 32'h0000_0034,  0, 1'b1, 32'h0,          1'b0, 2, 2};
    vt[10] = '{1'b0, 3, 32'h0,          0, 1'b1, 32'h0000_0034,  1'b0, 2, 3};
    vt[11] = '{1'b1, 1, 32'h0000_FFFF, 10, 1'b0, 32'h0,          1'b1, 5, 5};
    vt[12] = '{1'b0, 1, 32'h0,          0, 1'b0, 32'hA5A5_0001,  1'b0, 2, 3};
    vt[13] = '{1'b0, 0, 32'h0,         50, 1'b0, 32'h0,          1'b0, 99, 99};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      if (!vt[i].b2b) wait_idle();
      present(i);
      wait_accept();
    end
    wait_idle();

    // Abort a stalled read with reset partway through ACCESS.
    present(NV);
    wait_accept();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
